fsm_sequencer: RTL and testbench

- Parametrised successor to the single-shot datapath FSM.
- Runs a programmable sequence of up to NUM_STEPS instructions against one datapath, using the start/hold/wait handshake for each step.
- Optionally chains each step's result into the next step's instruction; adds abort, a per-step timeout and per-step result reporting.
- Sits between a top-level controller (start/finished) and a datapath (start_dp/instruction_dp/finished_dp/result_dp).

---
 rtl/fsm_sequencer_if.sv | 27 ++
 rtl/fsm_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_fsm_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_sequencer_if.sv
// Datapath-side bundle between fsm_sequencer (master) and the datapath it drives (slave).
interface fsm_sequencer_if #(
  parameter int IW = 32,
  parameter int RW = 32
);
  // Handshake: the master raises start_dp with instruction_dp stable and holds it for a fixed
  // number of cycles, then drops it. The slave later pulses finished_dp, and result_dp is only
  // meaningful in a cycle where finished_dp is high. There is no backpressure in either direction.
  logic          start_dp;
  logic [IW-1:0] instruction_dp;
  logic          finished_dp;
  logic [RW-1:0] result_dp;

  modport master (
    output start_dp,
    output instruction_dp,
    input  finished_dp,
    input  result_dp
  );

  modport slave (
    input  start_dp,
    input  instruction_dp,
    output finished_dp,
    output result_dp
  );
endinterface

// File: rtl/fsm_sequencer.sv
// Runs up to NUM_STEPS datapath instructions back to back, optionally feeding each result
// into the next instruction, with abort, per-step timeout and per-step result reporting.
module fsm_sequencer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int RESULT_WIDTH      = 32,
  parameter int NUM_STEPS         = 8,
  parameter int START_HOLD        = 2,
  parameter int TIMEOUT           = 1024,
  parameter int CHAIN_BITS        = 28,
  localparam int STEP_W = $clog2(NUM_STEPS + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [STEP_W-1:0]                    step_count,
  input  logic                                 chain_en,
  input  logic [NUM_STEPS*INSTRUCTION_WIDTH-1:0] program_i,
  output logic                                 finished,
  output logic                                 error,
  output logic [STEP_W-1:0]                    step_index,
  output logic                                 step_valid,
  output logic [RESULT_WIDTH-1:0]              step_result,
  output logic [1:0]                           state_dbg,
  fsm_sequencer_if.master                      dp
);

  localparam int IW     = INSTRUCTION_WIDTH;
  localparam int RW     = RESULT_WIDTH;
  localparam int NSLOT  = 1 << STEP_W;
  localparam int HOLD_W = $clog2(START_HOLD + 1);
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(START_HOLD);
  localparam logic [STEP_W-1:0] STEPS_MAX  = STEP_W'(NUM_STEPS);
  localparam logic [IW-1:0]     CHAIN_MASK = ~({IW{1'b1}} << CHAIN_BITS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_HOLD = 2'd2, S_WAIT = 2'd3} state_t;

  state_t            state_q, state_d;
  logic              finished_q, finished_d;
  logic              error_q, error_d;
  logic              step_valid_q, step_valid_d;
  logic [STEP_W-1:0] step_index_q, step_index_d;
  logic [RW-1:0]     step_result_q, step_result_d;
  logic              start_dp_q, start_dp_d;
  logic [IW-1:0]     instr_q, instr_d;
  logic [STEP_W-1:0] count_q, count_d;
  logic              chain_q, chain_d;
  logic [RW-1:0]     chain_reg_q, chain_reg_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  // Power-of-two word table so any step_index value selects a defined entry.
  logic [IW-1:0] prog_words [NSLOT];
  for (genvar k = 0; k < NSLOT; k++) begin : g_words
    if (k < NUM_STEPS) begin : g_used
      assign prog_words[k] = program_i[k*IW +: IW];
    end else begin : g_pad
      assign prog_words[k] = '0;
    end
  end

  logic [STEP_W-1:0] count_clamp;
  logic [IW-1:0]     chained_instr;
  assign count_clamp   = (step_count > STEPS_MAX) ? STEPS_MAX : step_count;
  assign chained_instr = (prog_words[step_index_q] & ~CHAIN_MASK) | (IW'(chain_reg_q) & CHAIN_MASK);

  always_comb begin
    state_d       = state_q;
    finished_d    = finished_q;
    error_d       = error_q;
    step_valid_d  = 1'b0;
    step_index_d  = step_index_q;
    step_result_d = step_result_q;
    start_dp_d    = start_dp_q;
    instr_d       = instr_q;
    count_d       = count_q;
    chain_d       = chain_q;
    chain_reg_d   = chain_reg_q;
    hold_d        = hold_q;
    tmo_d         = tmo_q;
    if (state_q != S_IDLE && abort) begin
      start_dp_d = 1'b0;
      finished_d = 1'b1;
      state_d    = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          finished_d = 1'b1;
          if (start && !abort) begin
            count_d = count_clamp;
            chain_d = chain_en;
            error_d = 1'b0;
            if (count_clamp != '0) begin
              finished_d   = 1'b0;
              step_index_d = '0;
              state_d      = S_START;
            end
          end
        end
        S_START: begin
          start_dp_d = 1'b1;
          hold_d     = HOLD_W'(1);
          instr_d    = (chain_q && step_index_q != '0) ? chained_instr : prog_words[step_index_q];
          state_d    = S_HOLD;
        end
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            start_dp_d = 1'b0;
            tmo_d      = '0;
            state_d    = S_WAIT;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        S_WAIT: begin
          if (dp.finished_dp) begin
            step_result_d = dp.result_dp;
            chain_reg_d   = dp.result_dp;
            step_valid_d  = 1'b1;
            if (step_index_q == count_q - STEP_W'(1)) begin
              finished_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              step_index_d = step_index_q + STEP_W'(1);
              state_d      = S_START;
            end
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
            if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
              error_d    = 1'b1;
              finished_d = 1'b1;
              state_d    = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      finished_q    <= 1'b1;
      error_q       <= 1'b0;
      step_valid_q  <= 1'b0;
      step_index_q  <= '0;
      step_result_q <= '0;
      start_dp_q    <= 1'b0;
      instr_q       <= '0;
      count_q       <= '0;
      chain_q       <= 1'b0;
      chain_reg_q   <= '0;
      hold_q        <= '0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      finished_q    <= finished_d;
      error_q       <= error_d;
      step_valid_q  <= step_valid_d;
      step_index_q  <= step_index_d;
      step_result_q <= step_result_d;
      start_dp_q    <= start_dp_d;
      instr_q       <= instr_d;
      count_q       <= count_d;
      chain_q       <= chain_d;
      chain_reg_q   <= chain_reg_d;
      hold_q        <= hold_d;
      tmo_q         <= tmo_d;
    end
  end

  assign finished          = finished_q;
  assign error             = error_q;
  assign step_valid        = step_valid_q;
  assign step_index        = step_index_q;
  assign step_result       = step_result_q;
  assign state_dbg         = state_q;
  assign dp.start_dp       = start_dp_q;
  assign dp.instruction_dp = instr_q;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Bench for fsm_sequencer: table-driven scenarios, hand-written corner sequences and
// randomized programs checked against a step-level reference model.
module tb_fsm_sequencer;
  localparam int NS   = 8;
  localparam int IW   = 32;
  localparam int RW   = 32;
  localparam int SW   = 4;
  localparam int TMO  = 16;
  localparam int HOLD = 2;
  localparam logic [31:0] CMASK = 32'h0FFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic              start = 1'b0;
  logic              abort;
  logic [SW-1:0]     step_count = '0;
  logic              chain_en = 1'b0;
  logic [NS*IW-1:0]  program_w = '0;
  logic              finished, error, step_valid;
  logic [SW-1:0]     step_index;
  logic [RW-1:0]     step_result;
  logic [1:0]        state_dbg;

  fsm_sequencer_if #(.IW(IW), .RW(RW)) dif ();

  fsm_sequencer #(
    .INSTRUCTION_WIDTH(IW), .RESULT_WIDTH(RW), .NUM_STEPS(NS),
    .START_HOLD(HOLD), .TIMEOUT(TMO), .CHAIN_BITS(28)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .step_count(step_count), .chain_en(chain_en), .program_i(program_w),
    .finished(finished), .error(error), .step_index(step_index),
    .step_valid(step_valid), .step_result(step_result), .state_dbg(state_dbg),
    .dp(dif)
  );

  // ---------------- scenario knobs ----------------
  logic [31:0] prog [NS];
  logic [31:0] res  [NS];
  int          lat  [NS];
  int          amode[NS];   // 0 none, 1 abort with finished_dp, 2 abort in first hold cycle
  bit          spurious = 1'b0;
  bit          force_abort = 1'b0;
  int          seq_id = 0;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- datapath responder (also owns abort) ----------------
  int  rsp_seen = 0, rsp_rise = 0, rsp_cur = 0, rsp_wait = 0;
  bit  rsp_waiting = 1'b0;
  logic rsp_prev = 1'b0;
  always @(negedge clock) begin
    dif.finished_dp = 1'b0;
    dif.result_dp   = '0;
    abort           = force_abort;
    if (seq_id != rsp_seen) begin
      rsp_seen = seq_id; rsp_rise = 0; rsp_waiting = 1'b0;
    end
    if (dif.start_dp && !rsp_prev) begin
      rsp_cur = (rsp_rise < NS) ? rsp_rise : NS - 1;
      rsp_rise++;
      if (amode[rsp_cur] == 2) abort = 1'b1;
    end
    if (spurious && dif.start_dp) begin
      dif.finished_dp = 1'b1; dif.result_dp = 32'hDEAD_BEEF;
    end
    if (!dif.start_dp && rsp_prev) begin
      rsp_waiting = 1'b1; rsp_wait = lat[rsp_cur];
    end
    if (rsp_waiting) begin
      if (rsp_wait == 0) begin
        rsp_waiting = 1'b0;
        dif.finished_dp = 1'b1; dif.result_dp = res[rsp_cur];
        if (amode[rsp_cur] == 1) abort = 1'b1;
      end else begin
        rsp_wait--;
      end
    end
    rsp_prev = dif.start_dp;
  end

  // ---------------- monitor ----------------
  logic [31:0] got_instr[$];
  logic [31:0] got_res[$];
  int          got_hold[$];
  logic        got_fin_sv[$];
  int   hold_run = 0;
  logic mon_prev = 1'b0;
  always @(negedge clock) begin
    if (dif.start_dp) begin
      if (!mon_prev) begin got_instr.push_back(dif.instruction_dp); hold_run = 0; end
      hold_run++;
    end else if (mon_prev) begin
      got_hold.push_back(hold_run);
    end
    if (step_valid) begin
      got_res.push_back(step_result);
      got_fin_sv.push_back(finished);
    end
    mon_prev = dif.start_dp;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] exp_q[$];     // expected instructions
  logic [31:0] exp_r[$];     // expected step results
  int          exp_h[$];     // expected start_dp high durations
  logic        m_err = 1'b0;
  int          m_idx = 0;
  logic [31:0] m_result = '0;

  task automatic run_seq(input int cnt, input bit ch);
    int n, w;
    bit done;
    logic [31:0] prev, ins;
    exp_q.delete(); exp_r.delete(); exp_h.delete();
    n = (cnt > NS) ? NS : cnt;
    done = 1'b0; prev = '0; m_err = 1'b0;
    for (int s = 0; s < n && !done; s++) begin
      ins = prog[s];
      if (ch && s > 0) ins = (prog[s] & ~CMASK) | (prev & CMASK);
      exp_q.push_back(ins);
      m_idx = s;
      if (amode[s] == 2) begin
        exp_h.push_back(1); done = 1'b1;
      end else begin
        exp_h.push_back(HOLD);
        if (lat[s] >= TMO) begin
          m_err = 1'b1; done = 1'b1;
        end else if (amode[s] == 1) begin
          done = 1'b1;
        end else begin
          exp_r.push_back(res[s]); prev = res[s]; m_result = res[s];
        end
      end
    end
    // drive
    got_instr.delete(); got_res.delete(); got_hold.delete(); got_fin_sv.delete();
    for (int k = 0; k < NS; k++) program_w[k*IW +: IW] = prog[k];
    step_count = SW'(cnt);
    chain_en = ch;
    seq_id++;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    w = 0;
    while (!finished && w < 3000) begin @(negedge clock); w++; end
    check("seq_done", {63'd0, finished}, 64'd1);
    repeat (3) @(negedge clock);
    check("n_instr", got_instr.size(), exp_q.size());
    check("n_result", got_res.size(), exp_r.size());
    check("n_hold", got_hold.size(), exp_h.size());
    for (int i = 0; i < exp_q.size() && i < got_instr.size(); i++) check("instr", got_instr[i], exp_q[i]);
    for (int i = 0; i < exp_r.size() && i < got_res.size(); i++) check("result", got_res[i], exp_r[i]);
    for (int i = 0; i < exp_h.size() && i < got_hold.size(); i++) check("hold_len", got_hold[i], exp_h[i]);
    check("error", {63'd0, error}, {63'd0, m_err});
    check("step_index", {60'd0, step_index}, 64'(m_idx));
    check("step_result", {32'd0, step_result}, {32'd0, m_result});
    check("idle_start_dp", {63'd0, dif.start_dp}, 64'd0);
  endtask

  task automatic set_knobs(input int l, input int am_step, input int am);
    for (int k = 0; k < NS; k++) begin
      lat[k] = l;
      amode[k] = (k == am_step) ? am : 0;
    end
  endtask

  typedef struct {
    int cnt; bit ch; int l; int am_step; int am;
    int x_instr; int x_res; bit x_err; int x_idx;
  } vec_t;
  vec_t tbl[9];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int w, r;
    for (int k = 0; k < NS; k++) begin prog[k] = 32'hA + k; res[k] = k + 1; end
    set_knobs(3, 0, 0);
    tbl[0] = '{3,  1'b0, 4,  0, 0, 3, 3, 1'b0, 2};
    tbl[1] = '{0,  1'b0, 4,  0, 0, 0, 0, 1'b0, 2};
    tbl[2] = '{15, 1'b0, 2,  0, 0, 8, 8, 1'b0, 7};
    tbl[3] = '{4,  1'b0, 3,  1, 1, 2, 1, 1'b0, 1};
    tbl[4] = '{2,  1'b0, 40, 0, 0, 1, 0, 1'b1, 0};
    tbl[5] = '{2,  1'b0, 15, 0, 0, 2, 2, 1'b0, 1};
    tbl[6] = '{1,  1'b0, 16, 0, 0, 1, 0, 1'b1, 0};
    tbl[7] = '{3,  1'b1, 5,  2, 2, 3, 2, 1'b0, 2};
    tbl[8] = '{1,  1'b0, 0,  0, 0, 1, 1, 1'b0, 0};

    // reset values
    repeat (3) @(negedge clock);
    check("rst_finished", {63'd0, finished}, 64'd1);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_step_valid", {63'd0, step_valid}, 64'd0);
    check("rst_step_index", {60'd0, step_index}, 64'd0);
    check("rst_step_result", {32'd0, step_result}, 64'd0);
    check("rst_start_dp", {63'd0, dif.start_dp}, 64'd0);
    check("rst_instr", {32'd0, dif.instruction_dp}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // three-step run, results 1,2,3
    run_seq(3, 1'b0);
    if (got_instr.size() == 3 && got_res.size() == 3 && got_hold.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("three_instr", got_instr[i], 32'hA + i);
        check("three_result", got_res[i], i + 1);
        check("three_hold", got_hold[i], 2);
        check("three_fin_at_pulse", {63'd0, got_fin_sv[i]}, (i == 2) ? 64'd1 : 64'd0);
      end
    end else begin
      check("three_sizes", got_res.size(), 3);
    end

    // chaining: step 1 takes low 28 bits of step 0 result
    prog[0] = 32'h1111_1111; prog[1] = 32'h5000_0000;
    res[0]  = 32'h0123_4567; res[1]  = 32'h0000_0042;
    run_seq(2, 1'b1);
    if (got_instr.size() >= 2) check("chain_instr", got_instr[1], 32'h5123_4567);
    else check("chain_n_instr", got_instr.size(), 2);

    // table of scenarios
    for (int k = 0; k < NS; k++) begin prog[k] = 32'hA + k; res[k] = k + 1; end
    for (int i = 0; i < 9; i++) begin
      set_knobs(tbl[i].l, tbl[i].am_step, tbl[i].am);
      spurious = i[0];
      run_seq(tbl[i].cnt, tbl[i].ch);
      check("tbl_n_instr", got_instr.size(), tbl[i].x_instr);
      check("tbl_n_result", got_res.size(), tbl[i].x_res);
      check("tbl_error", {63'd0, error}, {63'd0, tbl[i].x_err});
      check("tbl_step_index", {60'd0, step_index}, 64'(tbl[i].x_idx));
    end
    spurious = 1'b0;

    // reset during the second hold cycle
    set_knobs(4, 0, 0);
    program_w = '1;
    step_count = 4'd2; chain_en = 1'b0; seq_id++;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    w = 0;
    while (!dif.start_dp && w < 20) begin @(negedge clock); w++; end
    check("hold_seen", {63'd0, dif.start_dp}, 64'd1);
    @(negedge clock);
    check("hold_second", {63'd0, dif.start_dp}, 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_finished", {63'd0, finished}, 64'd1);
    check("mid_rst_start_dp", {63'd0, dif.start_dp}, 64'd0);
    check("mid_rst_instr", {32'd0, dif.instruction_dp}, 64'd0);
    check("mid_rst_step_index", {60'd0, step_index}, 64'd0);
    check("mid_rst_step_result", {32'd0, step_result}, 64'd0);
    check("mid_rst_error", {63'd0, error}, 64'd0);
    check("mid_rst_step_valid", {63'd0, step_valid}, 64'd0);
    reset = 1'b0;
    m_idx = 0; m_result = '0; m_err = 1'b0;
    repeat (2) @(negedge clock);

    // start together with abort in IDLE is not accepted
    got_instr.delete();
    force_abort = 1'b1;
    @(negedge clock);
    step_count = 4'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0; force_abort = 1'b0;
    repeat (4) @(negedge clock);
    check("idle_abort_finished", {63'd0, finished}, 64'd1);
    check("idle_abort_no_step", got_instr.size(), 0);

    // randomized programs
    for (int t = 0; t < 24; t++) begin
      int cnt;
      cnt = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) cnt = 15;
      for (int k = 0; k < NS; k++) begin
        prog[k] = $urandom;
        res[k]  = $urandom;
        lat[k]  = ($urandom_range(0, 11) == 0) ? 40 : $urandom_range(0, 12);
        r = $urandom_range(0, 15);
        amode[k] = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      end
      spurious = $urandom_range(0, 1);
      run_seq(cnt, $urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
